// File: rtl/packet_injector.sv
// packet_injector: local-port packet injector for a mesh router node.
// Takes a packet request (destination, payload length) plus payload words
// from the processing element and pushes one header flit followed by the
// payload flits into the router's local input buffer, honouring buffer_full.
//
// Optional build macro: PKT_INJ_SELF_DROP_EN
//   When defined, requests addressed to this node ({NODE_X, NODE_Y}) drain
//   their payload from the PE without sending anything to the router.
//   When undefined (default), self-addressed packets are injected normally.
module packet_injector #(
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [7:0]  req_dest,
  input  logic [7:0]  req_len,
  output logic        req_ready,
  input  logic [15:0] pe_data,
  input  logic        pe_valid,
  output logic        pe_ready,
  output logic [15:0] flit_data,
  output logic        flit_valid,
  input  logic        buffer_full,
  output logic        busy,
  output logic [15:0] pkt_count
);

`ifdef PKT_INJ_SELF_DROP_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [7:0] SELF_ADDR = {NODE_X[3:0], NODE_Y[3:0]};
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] hdr_q, hdr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [15:0] pkt_count_q, pkt_count_d;

  // Next-state, header latch, remaining-flit and completed-packet counters.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    remaining_d = remaining_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hdr_d       = {req_len, req_dest};
          remaining_d = req_len;
          state_d     = HEADER;
`ifdef PKT_INJ_SELF_DROP_EN
          if (req_dest == SELF_ADDR) begin
            state_d = DROP;
          end
`endif
        end
      end
      HEADER: begin
        if (!buffer_full) begin
          if (remaining_q == 8'd0) begin
            state_d     = IDLE;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pe_valid && !buffer_full) begin
          // Last-flit check happens on the pre-decrement value so the
          // counter lands on zero and never wraps below it.
          if (remaining_q == 8'd1) begin
            state_d     = IDLE;
            pkt_count_d = pkt_count_q + 16'd1;
          end
          remaining_d = remaining_q - 8'd1;
        end
      end
`ifdef PKT_INJ_SELF_DROP_EN
      DROP: begin
        if (remaining_q == 8'd0) begin
          state_d = IDLE;
        end else if (pe_valid) begin
          if (remaining_q == 8'd1) begin
            state_d = IDLE;
          end
          remaining_d = remaining_q - 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, remaining count and packet counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Header word holding register; only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
  end

  // Handshake and flit outputs; everything except pkt_count is held at zero
  // for any cycle in which reset is asserted.
  always_comb begin
    req_ready  = 1'b0;
    pe_ready   = 1'b0;
    flit_valid = 1'b0;
    flit_data  = 16'h0000;
    busy       = 1'b0;
    if (rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
        end
        HEADER: begin
          flit_valid = !buffer_full;
          flit_data  = hdr_q;
        end
        PAYLOAD: begin
          pe_ready   = !buffer_full;
          flit_valid = pe_valid && !buffer_full;
          flit_data  = pe_data;
        end
`ifdef PKT_INJ_SELF_DROP_EN
        DROP: begin
          // A zero-length dropped packet must not swallow an unrelated word.
          pe_ready = (remaining_q != 8'd0);
        end
`endif
        default: begin
          req_ready = 1'b0;
        end
      endcase
    end
  end

  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: directed bench for packet_injector (NODE = (1,1)).
module tb_packet_injector;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [7:0]  req_dest;
  logic [7:0]  req_len;
  logic        req_ready;
  logic [15:0] pe_data;
  logic        pe_valid;
  logic        pe_ready;
  logic [15:0] flit_data;
  logic        flit_valid;
  logic        buffer_full;
  logic        busy;
  logic [15:0] pkt_count;

  int n_chk;
  int n_pass;

  packet_injector #(
    .NODE_X(1),
    .NODE_Y(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .pe_data    (pe_data),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .flit_data  (flit_data),
    .flit_valid (flit_valid),
    .buffer_full(buffer_full),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Apply inputs just after a falling edge, then let combinational outputs settle.
  task automatic step(input logic rv, input logic [7:0] rd, input logic [7:0] rl,
                      input logic pv, input logic [15:0] pd, input logic bf);
    @(negedge clk);
    req_valid   = rv;
    req_dest    = rd;
    req_len     = rl;
    pe_valid    = pv;
    pe_data     = pd;
    buffer_full = bf;
    #1;
  endtask

  task automatic chk_flit(input string tag, input logic ev, input logic [15:0] ed, input logic epr);
    chk({tag, "_valid"}, {15'd0, flit_valid}, {15'd0, ev});
    chk({tag, "_data"}, flit_data, ed);
    chk({tag, "_pe_ready"}, {15'd0, pe_ready}, {15'd0, epr});
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] ecnt);
    chk({tag, "_req_ready"}, {15'd0, req_ready}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_flit_valid"}, {15'd0, flit_valid}, 16'd0);
    chk({tag, "_pkt_count"}, pkt_count, ecnt);
  endtask

  // Zero-length packet: accept, header flit, back in IDLE with count bumped.
  task automatic zlp(input string tag, input logic [7:0] dest, input logic [15:0] cnt_after);
    step(1'b1, dest, 8'd0, 1'b0, 16'h0, 1'b0);
    chk({tag, "_accept"}, {15'd0, req_ready}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_flit({tag, "_hdr"}, 1'b1, {8'h00, dest}, 1'b0);
    chk({tag, "_hdr_req_ready"}, {15'd0, req_ready}, 16'd0);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_idle({tag, "_done"}, cnt_after);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_dest    = 8'h00;
    req_len     = 8'h00;
    pe_valid    = 1'b0;
    pe_data     = 16'h0000;
    buffer_full = 1'b0;

    // Reset: outputs forced low, counter cleared.
    step(1'b1, 8'h23, 8'd3, 1'b1, 16'hFFFF, 1'b0);
    chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
    chk("rst_pe_ready", {15'd0, pe_ready}, 16'd0);
    chk("rst_flit_valid", {15'd0, flit_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_flit_data", flit_data, 16'h0000);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk("rst_pkt_count", pkt_count, 16'h0000);
    rst = 1'b1;
    #1;
    chk_idle("post_rst", 16'd0);

    // Single packet: dest 0x23, three payload words.
    step(1'b1, 8'h23, 8'd3, 1'b0, 16'h0, 1'b0);
    chk("sp_accept", {15'd0, req_ready}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hBEEF, 1'b0);
    chk_flit("sp_hdr", 1'b1, 16'h0323, 1'b0);
    chk("sp_hdr_busy", {15'd0, busy}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hA001, 1'b0);
    chk_flit("sp_p1", 1'b1, 16'hA001, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hA002, 1'b0);
    chk_flit("sp_p2", 1'b1, 16'hA002, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hA003, 1'b0);
    chk_flit("sp_p3", 1'b1, 16'hA003, 1'b1);
    chk("sp_p3_count", pkt_count, 16'd0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hA004, 1'b0);
    chk_idle("sp_done", 16'd1);
    chk("sp_idle_pe_ready", {15'd0, pe_ready}, 16'd0);

    // Zero-length packet.
    zlp("zl", 8'h10, 16'd2);

    // Backpressure on header, 2nd payload flit and last payload flit.
    step(1'b1, 8'h45, 8'd3, 1'b0, 16'h0, 1'b0);
    chk("bp_accept", {15'd0, req_ready}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB001, 1'b1);
      chk_flit("bp_hdr_stall", 1'b0, 16'h0345, 1'b0);
    end
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB001, 1'b0);
    chk_flit("bp_hdr", 1'b1, 16'h0345, 1'b0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB001, 1'b0);
    chk_flit("bp_p1", 1'b1, 16'hB001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB002, 1'b1);
      chk_flit("bp_p2_stall", 1'b0, 16'hB002, 1'b0);
    end
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB002, 1'b0);
    chk_flit("bp_p2", 1'b1, 16'hB002, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB003, 1'b1);
    chk_flit("bp_last_stall", 1'b0, 16'hB003, 1'b0);
    chk("bp_last_stall_busy", {15'd0, busy}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hB003, 1'b0);
    chk_flit("bp_p3", 1'b1, 16'hB003, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_idle("bp_done", 16'd3);

    // Reset mid-packet after two of five payload flits.
    step(1'b1, 8'h56, 8'd5, 1'b0, 16'h0, 1'b0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hC001, 1'b0);
    chk_flit("mr_hdr", 1'b1, 16'h0556, 1'b0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hC001, 1'b0);
    chk_flit("mr_p1", 1'b1, 16'hC001, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hC002, 1'b0);
    chk_flit("mr_p2", 1'b1, 16'hC002, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hC003, 1'b0);
    rst = 1'b0;
    #1;
    chk_flit("mr_rst", 1'b0, 16'h0000, 1'b0);
    chk("mr_rst_busy", {15'd0, busy}, 16'd0);
    chk("mr_rst_req_ready", {15'd0, req_ready}, 16'd0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hC003, 1'b0);
    chk("mr_rst_count", pkt_count, 16'd0);
    rst = 1'b1;
    pe_valid = 1'b0;
    #1;
    chk_idle("mr_post", 16'd0);
    step(1'b1, 8'h12, 8'd1, 1'b0, 16'h0, 1'b0);
    chk("mr_new_accept", {15'd0, req_ready}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hD001, 1'b0);
    chk_flit("mr_new_hdr", 1'b1, 16'h0112, 1'b0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hD001, 1'b0);
    chk_flit("mr_new_p1", 1'b1, 16'hD001, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_idle("mr_new_done", 16'd1);

    // Self-addressed packet (this node is (1,1)).
    step(1'b1, 8'h11, 8'd2, 1'b0, 16'h0, 1'b0);
    chk("sd_accept", {15'd0, req_ready}, 16'd1);
`ifdef PKT_INJ_SELF_DROP_EN
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hE001, 1'b0);
    chk("sd_d1_valid", {15'd0, flit_valid}, 16'd0);
    chk("sd_d1_pe_ready", {15'd0, pe_ready}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hE002, 1'b0);
    chk("sd_d2_valid", {15'd0, flit_valid}, 16'd0);
    chk("sd_d2_pe_ready", {15'd0, pe_ready}, 16'd1);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_idle("sd_done", 16'd1);
`else
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hE001, 1'b0);
    chk_flit("sd_hdr", 1'b1, 16'h0211, 1'b0);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hE001, 1'b0);
    chk_flit("sd_p1", 1'b1, 16'hE001, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b1, 16'hE002, 1'b0);
    chk_flit("sd_p2", 1'b1, 16'hE002, 1'b1);
    step(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0);
    chk_idle("sd_done", 16'd2);
`endif

    // Counter wrap: start just below the top, then finish three packets.
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.pkt_count_q;
    #1;
    chk("wr_preload", pkt_count, 16'hFFFD);
    zlp("wr1", 8'h20, 16'hFFFE);
    zlp("wr2", 8'h30, 16'hFFFF);
    zlp("wr3", 8'h40, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
# packet_injector

Local-port packet injector for a mesh router node. Accepts a packet request (destination, payload length) and payload words from the processing element, then emits one header flit followed by the payload flits into the router's local input buffer. Respects the router's buffer-full backpressure. Sits directly upstream of the router's local interface: its flit outputs drive the local buffer push, data and full signals.

## Interface

**Parameters**
- `NODE_X`, default 0: this node's X coordinate (4 bits used).
- `NODE_Y`, default 0: this node's Y coordinate (4 bits used).

**Ports**
- `clk`  input  1: clock.
- `rst`  input  1: synchronous, active-low reset.
- `req_valid`  input  1: packet request present.
- `req_dest`  input  8: destination, {X[3:0], Y[3:0]}.
- `req_len`  input  8: payload flit count N, 0..255.
- `req_ready`  output  1: request accepted when `req_valid && req_ready`.
- `pe_data`  input  16: payload word.
- `pe_valid`  input  1: payload word present.
- `pe_ready`  output  1: payload word consumed when `pe_valid && pe_ready`.
- `flit_data`  output  16: flit to router local buffer.
- `flit_valid`  output  1: push strobe to router local buffer.
- `buffer_full`  input  1: router local buffer full.
- `busy`  output  1: packet in progress (state ≠ IDLE).
- `pkt_count`  output  16: packets completed, wrapping.

## Operation

**Header flit format**
- `[15:8]` = N.
- `[7:0]` = `req_dest`.
- Downstream address tracking relies on N being exactly the number of payload flits that follow.

**States**
- IDLE
  - `req_ready` = 1.
  - On accept: latch the header and N into `remaining`, then go to HEADER.
  - Under `PKT_INJ_SELF_DROP_EN`, a request with `req_dest == {NODE_X[3:0], NODE_Y[3:0]}` goes to DROP instead.
- HEADER
  - `flit_valid = !buffer_full`.
  - `flit_data` = latched header.
  - On a send with N == 0: go to IDLE and increment `pkt_count`.
  - On a send with N > 0: go to PAYLOAD.
- PAYLOAD
  - `pe_ready = !buffer_full`.
  - `flit_valid = pe_valid && !buffer_full`.
  - `flit_data = pe_data` (combinational pass-through).
  - Each transfer decrements `remaining`.
  - A transfer with `remaining == 1` goes to IDLE and increments `pkt_count`.
- DROP (macro only)
  - `pe_ready` = 1 and `flit_valid` = 0.
  - Consumes N words.
  - If N == 0, it returns to IDLE after one cycle.
  - Does not increment `pkt_count`.

**Output defaults and rules**
- Outside these rules: `flit_valid` = 0, `pe_ready` = 0, `flit_data` = 16'h0000.
- `req_ready` = 0 in every state except IDLE.
- `pe_valid` seen in IDLE or HEADER is ignored: no consumption.
- `buffer_full` is sampled combinationally in the same cycle. A flit is never pushed while `buffer_full` = 1, and holding `buffer_full` high stalls indefinitely with no loss.
- `remaining` is 8 bits and never underflows: the last-flit check precedes the decrement.
- `pkt_count` wraps 16'hFFFF → 16'h0000.

## Timing

**Reset**
- While `rst` = 0 at a clock edge, the next state is IDLE and `remaining` = 0, `pkt_count` = 0.
- During any cycle with `rst` = 0, all outputs are forced to 0: `req_ready`, `pe_ready`, `flit_valid`, `busy`, `flit_data`.
- Reset mid-packet abandons the packet. No further flits are sent, and `pkt_count` is cleared.

**Latency**
- Request accept to header on `flit_valid`: 1 cycle, if not full.
- Header to first payload transfer: 1 cycle minimum.
- Back-to-back payload flits: 1 per cycle.

**Packet spacing**
- A packet of N payload flits occupies at least N+2 cycles from accept to the next `req_ready`: accept, header, N payload flits, then IDLE.
- The IDLE cycle is mandatory between packets.

**Simultaneous events**
- `buffer_full` rising in the same cycle as the last payload flit: that flit is not sent. The state stays PAYLOAD with `remaining` = 1.
- `pkt_count` increments on the edge after the completing transfer.

## Configuration

- `PKT_INJ_SELF_DROP_EN`
  - **Defined:** self-addressed requests enter DROP. Their payload is drained from the PE, and nothing reaches the router.
  - **Undefined:** the DROP state does not exist. Self-addressed packets are injected like any other packet; the router's local output returns them.

## Test plan

- **Single packet:** NODE=(1,1), req_dest=8'h23, req_len=3, `pe_data` 16'hA001/A002/A003, `buffer_full`=0.
  - Flits 16'h0323, A001, A002, A003 on consecutive cycles.
  - `pkt_count`=1.
  - `req_ready` reasserts 1 cycle after the last flit.
- **Zero-length:** req_dest=8'h10, req_len=0.
  - Single flit 16'h0010.
  - IDLE next cycle; `pkt_count` increments.
- **Backpressure:** `buffer_full`=1 for 4 cycles during HEADER, then during the 2nd payload flit.
  - `flit_valid` and `pe_ready` are 0 throughout each stall.
  - Exact flit sequence preserved, no duplicates.
- **Reset mid-packet:** `rst`=0 after 2 of 5 payload flits.
  - All outputs 0 during reset, `pkt_count`=0.
  - A subsequent request is accepted normally from IDLE.
- **Self-drop:** NODE=(2,3), req_dest=8'h23, req_len=2.
  - With the macro: 2 PE words consumed, `flit_valid` never asserts, `pkt_count` unchanged.
  - Without the macro: flits 16'h0223 then the 2 payload words.
- **Counter wrap:** preload via 65536 zero-length packets.
  - `pkt_count` returns to 16'h0000.
